// File: rtl/ddr_sched_pkg.sv
// rtl/ddr_sched_pkg.sv - shared DDR scheduler constants, FSM encoding and helpers
package ddr_sched_pkg;

  localparam int WIDTH_ddr_addr = 20;
  localparam int BEATS_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } sched_state_t;

  // Number of 64-bit words needed to carry a beat count, rounding up
  function automatic logic [WIDTH_ddr_addr-1:0] words_for_beats(input logic [WIDTH_ddr_addr-1:0] beats);
    logic [WIDTH_ddr_addr:0] w_sum;
    w_sum = {1'b0, beats} + (WIDTH_ddr_addr+1)'(BEATS_PER_WORD - 1);
    return WIDTH_ddr_addr'(w_sum >> 2);
  endfunction

endpackage

// File: rtl/ddr_wr_fifo.sv
// rtl/ddr_wr_fifo.sv - per-client 16-bit show-ahead FIFO with occupancy count
module ddr_wr_fifo #(
  parameter int SIZE = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [15:0]   i_data,
  input  logic          i_pop,
  output logic [15:0]   o_head,
  output logic [SIZE:0] o_count
);

  localparam int DEPTH = 1 << SIZE;

  logic [15:0]     r_mem [DEPTH];
  logic [SIZE-1:0] r_wr_ptr;
  logic [SIZE-1:0] r_rd_ptr;
  logic [SIZE:0]   r_count;
  logic            w_full;
  logic            w_do_push;
  logic            w_do_pop;

  assign w_full    = (r_count == (SIZE+1)'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);
  // A push into a full FIFO only lands if a pop frees the slot in the same cycle
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ddr_wr_scheduler.sv
// rtl/ddr_wr_scheduler.sv - round-robin burst write scheduler from client FIFOs to DDR
// Optional sticky overflow flags built when DDR_WR_OVF_CHECK_EN is defined.
module ddr_wr_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int                         SIZE_buffers    = 7,
  parameter int                         NUM             = 5,
  parameter int                         WIDTH_BASE_ADDR = 32,
  parameter logic [WIDTH_BASE_ADDR-1:0] BASE_ADDR0      = '0,
  parameter logic [WIDTH_BASE_ADDR-1:0] BASE_ADDR1      = '0,
  parameter logic [WIDTH_BASE_ADDR-1:0] BASE_ADDR2      = '0,
  parameter logic [WIDTH_BASE_ADDR-1:0] BASE_ADDR3      = '0,
  parameter logic [WIDTH_BASE_ADDR-1:0] BASE_ADDR4      = '0,
  parameter int                         MAX_WIDTH_Vaddr = 20,
  parameter int                         BURST_LEN       = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM-1:0]                 block_req,
  input  logic [NUM*MAX_WIDTH_Vaddr-1:0] flat__block_Vaddr,
  input  logic [NUM*18-1:0]              flat__data18bit,
  input  logic [NUM-1:0]                 data18bit_vld,
  output logic [NUM-1:0]                 block_full_ahead1,
  output logic [NUM-1:0]                 block_granted,
  output logic                           ddr_req,
  output logic [WIDTH_ddr_addr-1:0]      ddr_addr,
  output logic [WIDTH_ddr_addr-1:0]      ddr_len,
  input  logic                           ddr_ack,
  output logic [15:0]                    ddr_wr_data,
  input  logic                           ddr_wr_en,
  output logic [NUM-1:0]                 ovf_err
);

  localparam int CW         = SIZE_buffers + 1;
  localparam int DEPTH      = 1 << SIZE_buffers;
  localparam int FULL_BEATS = BEATS_PER_WORD * BURST_LEN;
  localparam int SELW       = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [WIDTH_BASE_ADDR-1:0] BASE [5] = '{BASE_ADDR0, BASE_ADDR1, BASE_ADDR2, BASE_ADDR3, BASE_ADDR4};

  sched_state_t              r_state;
  logic [SELW-1:0]           r_sel;
  logic [SELW-1:0]           r_rr;
  logic                      r_req;
  logic [WIDTH_ddr_addr-1:0] r_ddr_addr;
  logic [WIDTH_ddr_addr-1:0] r_ddr_len;
  logic [NUM-1:0]            r_granted;
  logic [CW-1:0]             r_beat;
  logic [CW-1:0]             r_last;
  logic [CW-1:0]             r_real;
  logic [NUM-1:0]            r_req_d;

  logic [15:0]               w_head  [NUM];
  logic [CW-1:0]             w_count [NUM];
  logic [WIDTH_ddr_addr-1:0] w_addr  [NUM];
  logic [NUM-1:0]            w_elig;
  logic [NUM-1:0]            w_pop;
  logic [NUM-1:0]            w_rise;
  logic [NUM-1:0]            w_claim;
  logic                      w_found;
  logic [SELW-1:0]           w_pick;
  logic [SELW:0]             w_j;
  logic [CW-1:0]             w_pick_cnt;
  logic [WIDTH_ddr_addr-1:0] w_pick_len;
  logic [CW-1:0]             w_pick_real;
  logic [CW-1:0]             w_pick_beats;
  logic                      w_in_data;
  logic                      w_end;

  assign w_rise    = block_req & ~r_req_d;
  assign w_in_data = (r_state == DATA) && (r_beat < r_real);
  assign w_end     = (r_state == DATA) && ddr_wr_en && (r_beat == r_last);
  assign w_claim   = ((r_state == IDLE) && w_found) ? (NUM'(1) << w_pick) : '0;

  for (genvar g = 0; g < NUM; g++) begin : g_client
    logic [WIDTH_ddr_addr-1:0] r_addr;
    logic [WIDTH_ddr_addr-1:0] r_pend_addr;
    logic                      r_pend;
    logic [WIDTH_ddr_addr-1:0] w_load_addr;
    logic                      w_unused_tag;

    assign w_unused_tag = ^flat__data18bit[g*18+16 +: 2];
    assign w_load_addr  = WIDTH_ddr_addr'(BASE[g])
                        + WIDTH_ddr_addr'(flat__block_Vaddr[g*MAX_WIDTH_Vaddr +: MAX_WIDTH_Vaddr]);

    ddr_wr_fifo #(.SIZE(SIZE_buffers)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (data18bit_vld[g]),
      .i_data  (flat__data18bit[g*18 +: 16]),
      .i_pop   (w_pop[g]),
      .o_head  (w_head[g]),
      .o_count (w_count[g])
    );

    assign w_pop[g]             = w_in_data && ddr_wr_en && (r_sel == SELW'(g));
    assign w_elig[g]            = (w_count[g] >= CW'(FULL_BEATS)) || (!block_req[g] && (w_count[g] != '0));
    assign block_full_ahead1[g] = (w_count[g] >= CW'(DEPTH - 2));
    assign w_addr[g]            = r_addr;

    // A new stream opened while this client owns the bus must not disturb the burst in flight
    always_ff @(posedge clk) begin
      if (reset) begin
        r_addr      <= '0;
        r_pend_addr <= '0;
        r_pend      <= 1'b0;
      end else if (w_end && (r_sel == SELW'(g))) begin
        if (r_pend)         r_addr <= r_pend_addr;
        else if (w_rise[g]) r_addr <= w_load_addr;
        else                r_addr <= r_addr + r_ddr_len;
        r_pend <= 1'b0;
      end else if (w_rise[g]) begin
        if (r_granted[g] || w_claim[g]) begin
          r_pend      <= 1'b1;
          r_pend_addr <= w_load_addr;
        end else begin
          r_addr <= w_load_addr;
        end
      end
    end

`ifdef DDR_WR_OVF_CHECK_EN
    logic r_ovf;
    always_ff @(posedge clk) begin
      if (reset)                                                  r_ovf <= 1'b0;
      else if (data18bit_vld[g] && (w_count[g] == CW'(DEPTH)))   r_ovf <= 1'b1;
    end
    assign ovf_err[g] = r_ovf;
`else
    assign ovf_err[g] = 1'b0;
`endif
  end

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_j     = '0;
    for (int k = 0; k < NUM; k++) begin
      w_j = {1'b0, r_rr} + (SELW+1)'(k);
      if (w_j >= (SELW+1)'(NUM)) w_j = w_j - (SELW+1)'(NUM);
      if (!w_found && w_elig[w_j[SELW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_j[SELW-1:0];
      end
    end
  end

  assign w_pick_cnt   = w_count[w_pick];
  assign w_pick_len   = (w_pick_cnt >= CW'(FULL_BEATS)) ? WIDTH_ddr_addr'(BURST_LEN)
                                                        : words_for_beats(WIDTH_ddr_addr'(w_pick_cnt));
  assign w_pick_real  = (w_pick_cnt >= CW'(FULL_BEATS)) ? CW'(FULL_BEATS) : w_pick_cnt;
  assign w_pick_beats = CW'({w_pick_len, 2'b00});

  always_ff @(posedge clk) begin
    r_req_d <= reset ? '0 : block_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_rr       <= '0;
      r_req      <= 1'b0;
      r_ddr_addr <= '0;
      r_ddr_len  <= '0;
      r_granted  <= '0;
      r_beat     <= '0;
      r_last     <= '0;
      r_real     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_sel      <= w_pick;
            r_ddr_addr <= w_addr[w_pick];
            r_ddr_len  <= w_pick_len;
            r_real     <= w_pick_real;
            r_last     <= w_pick_beats - 1'b1;
            r_beat     <= '0;
            r_req      <= 1'b1;
            r_granted  <= w_claim;
            r_state    <= CMD;
          end
        end
        CMD: begin
          if (ddr_ack) begin
            r_req   <= 1'b0;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (ddr_wr_en) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == r_last) begin
              r_granted <= '0;
              r_rr      <= (r_sel == SELW'(NUM - 1)) ? '0 : r_sel + 1'b1;
              r_state   <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ddr_req       = r_req;
  assign ddr_addr      = r_ddr_addr;
  assign ddr_len       = r_ddr_len;
  assign block_granted = r_granted;
  // Beats past the real sample count pad the final word with zeros
  assign ddr_wr_data   = w_in_data ? w_head[r_sel] : 16'h0000;

endmodule

// File: tb/tb_ddr_wr_scheduler.sv
// tb/tb_ddr_wr_scheduler.sv - directed self-checking bench for ddr_wr_scheduler
module tb_ddr_wr_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  block_req;
  logic [99:0] vaddr_flat;
  logic [89:0] data_flat;
  logic [4:0]  vld;
  logic [4:0]  full_ahead1;
  logic [4:0]  granted;
  logic        ddr_req;
  logic [19:0] ddr_addr;
  logic [19:0] ddr_len;
  logic        ddr_ack;
  logic [15:0] ddr_wr_data;
  logic        ddr_wr_en;
  logic [4:0]  ovf_err;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q [$];

`ifdef DDR_WR_OVF_CHECK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  ddr_wr_scheduler dut (
    .clk               (clk),
    .reset             (reset),
    .block_req         (block_req),
    .flat__block_Vaddr (vaddr_flat),
    .flat__data18bit   (data_flat),
    .data18bit_vld     (vld),
    .block_full_ahead1 (full_ahead1),
    .block_granted     (granted),
    .ddr_req           (ddr_req),
    .ddr_addr          (ddr_addr),
    .ddr_len           (ddr_len),
    .ddr_ack           (ddr_ack),
    .ddr_wr_data       (ddr_wr_data),
    .ddr_wr_en         (ddr_wr_en),
    .ovf_err           (ovf_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input int c, input logic [15:0] d);
    data_flat[c*18 +: 18] = {2'b11, d};
    vld[c] = 1'b1;
    tick();
    vld[c] = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    block_req = '0;
    vld       = '0;
    ddr_ack   = 1'b0;
    ddr_wr_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_burst(input string tag, input logic [19:0] ea, input logic [19:0] el, input logic [4:0] eg);
    int t;
    int nb;
    t = 0;
    while (ddr_req !== 1'b1 && t < 300) begin
      tick();
      t++;
    end
    chk({tag, "_req"}, ddr_req, 1);
    if (ddr_req !== 1'b1) return;
    chk({tag, "_addr"}, ddr_addr, ea);
    chk({tag, "_len"}, ddr_len, el);
    chk({tag, "_grant"}, granted, eg);
    repeat (5) tick();
    chk({tag, "_hold"}, {ddr_req, ddr_addr, ddr_len}, {1'b1, ea, el});
    ddr_ack = 1'b1;
    tick();
    ddr_ack = 1'b0;
    chk({tag, "_req_drop"}, ddr_req, 0);
    nb = 4 * int'(el);
    for (int b = 0; b < nb; b++) begin
      chk($sformatf("%s_beat%0d", tag, b), ddr_wr_data, (b < exp_q.size()) ? exp_q[b] : 16'h0);
      chk($sformatf("%s_onehot%0d", tag, b), granted, eg);
      ddr_wr_en = 1'b1;
      tick();
    end
    ddr_wr_en = 1'b0;
    chk({tag, "_release"}, {ddr_req, granted}, 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vaddr_flat = '0;
    data_flat  = '0;
    do_reset();
    chk("reset_outs", {ddr_req, ddr_addr, ddr_len, ddr_wr_data}, 0);
    chk("reset_flags", {granted, full_ahead1, ovf_err}, 0);

    // 1: client 2 full burst, then the follow-on address
    vaddr_flat[40 +: 20] = 20'd4;
    block_req[2] = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) push1(2, 16'(k));
    for (int k = 0; k < 32; k++) exp_q.push_back(16'(k));
    run_burst("t1", 20'd4, 20'd8, 5'b00100);
    for (int k = 0; k < 32; k++) push1(2, 16'(32 + k));
    for (int k = 0; k < 32; k++) exp_q.push_back(16'(32 + k));
    run_burst("t1_next", 20'd12, 20'd8, 5'b00100);

    // 2: clients 2 and 4 fill in the same cycle
    do_reset();
    vaddr_flat[40 +: 20] = 20'h40;
    vaddr_flat[80 +: 20] = 20'h80;
    block_req = 5'b10100;
    tick();
    for (int k = 0; k < 32; k++) begin
      data_flat[36 +: 18] = {2'b10, 16'(200 + k)};
      data_flat[72 +: 18] = {2'b01, 16'(300 + k)};
      vld = 5'b10100;
      tick();
    end
    vld = '0;
    for (int k = 0; k < 32; k++) exp_q.push_back(16'(200 + k));
    run_burst("t2_c2", 20'h40, 20'd8, 5'b00100);
    for (int k = 0; k < 32; k++) exp_q.push_back(16'(300 + k));
    run_burst("t2_c4", 20'h80, 20'd8, 5'b10000);

    // 3: client 1 short stream flushed with padding
    vaddr_flat[20 +: 20] = 20'h33;
    block_req = 5'b00010;
    tick();
    for (int k = 0; k < 6; k++) push1(1, 16'hA0 + 16'(k));
    block_req[1] = 1'b0;
    for (int k = 0; k < 6; k++) exp_q.push_back(16'hA0 + 16'(k));
    run_burst("t3", 20'h33, 20'd2, 5'b00010);

    // 5: address wraps modulo 2^20
    vaddr_flat[60 +: 20] = 20'hFFFFC;
    block_req[3] = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) push1(3, 16'h500 + 16'(k));
    for (int k = 0; k < 32; k++) exp_q.push_back(16'h500 + 16'(k));
    run_burst("t5_a", 20'hFFFFC, 20'd8, 5'b01000);
    for (int k = 0; k < 32; k++) push1(3, 16'h600 + 16'(k));
    for (int k = 0; k < 32; k++) exp_q.push_back(16'h600 + 16'(k));
    run_burst("t5_wrap", 20'd4, 20'd8, 5'b01000);
    block_req[3] = 1'b0;

    // 4: client 0 fills with the bus stalled, then 6: reset mid-burst
    vaddr_flat[0 +: 20] = 20'h10;
    block_req[0] = 1'b1;
    tick();
    for (int k = 0; k < 130; k++) begin
      push1(0, 16'(k));
      if (k == 124) chk("t4_ahead_125", full_ahead1[0], 0);
      if (k == 125) chk("t4_ahead_126", full_ahead1[0], 1);
      if (k == 127) chk("t4_ovf_at_full", ovf_err[0], 0);
    end
    chk("t4_ovf", ovf_err, {4'b0, OVF_EXP});
    chk("t4_cmd", {ddr_req, ddr_addr, ddr_len, granted}, {1'b1, 20'h10, 20'd8, 5'b00001});
    ddr_ack = 1'b1;
    tick();
    ddr_ack = 1'b0;
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("t6_beat%0d", b), ddr_wr_data, 16'(b));
      ddr_wr_en = 1'b1;
      tick();
    end
    ddr_wr_en = 1'b0;
    reset     = 1'b1;
    block_req = '0;
    tick();
    chk("t6_reset_req", {ddr_req, granted}, 0);
    chk("t6_reset_cnt", {full_ahead1, ovf_err, ddr_wr_data}, 0);
    reset = 1'b0;
    repeat (6) tick();
    chk("t6_no_flush", {ddr_req, granted}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
